// File: rtl/sec08_queues_stream_serializer.sv
// Width-adapting serializer: buffers one p_in_nbits word and emits it as N chunks on a val/rdy stream.
// Define SEC08_QUEUES_SERIALIZER_MSB_FIRST_EN to emit the most-significant chunk first (LSB first otherwise).
module sec08_queues_stream_serializer #(
   parameter int p_in_nbits  = 32,
   parameter int p_out_nbits = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   istream_val,
   output logic                   istream_rdy,
   input  logic [p_in_nbits-1:0]  istream_msg,
   output logic                   ostream_val,
   input  logic                   ostream_rdy,
   output logic [p_out_nbits-1:0] ostream_msg,
   output logic                   busy
);
   localparam int N  = p_in_nbits / p_out_nbits;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((p_out_nbits > p_in_nbits) || ((p_in_nbits % p_out_nbits) != 0)) begin : g_param_err
      $error("sec08_queues_stream_serializer: p_in_nbits must be a multiple of p_out_nbits");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 idx_q, idx_d;
   logic [N-1:0][p_out_nbits-1:0] buf_q, buf_d;
   logic                          last;
   logic                          xfer_in;
   logic                          xfer_out;

   assign last        = (state_q == SEND) && (idx_q == CW'(N-1));
   // Pipe-style: the last chunk leaving frees the buffer in the same cycle.
   assign istream_rdy = (state_q == IDLE) || (last && ostream_rdy);
   assign ostream_val = (state_q == SEND);
   assign busy        = (state_q == SEND);
   assign xfer_in     = istream_val && istream_rdy;
   assign xfer_out    = ostream_val && ostream_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            if (xfer_in) begin
               state_d = SEND;
               idx_d   = '0;
               buf_d   = istream_msg[N*p_out_nbits-1:0];
            end
         end
         SEND: begin
            if (xfer_out) begin
               if (!last) begin
                  idx_d = idx_q + CW'(1);
               end else if (xfer_in) begin
                  idx_d = '0;
                  buf_d = istream_msg[N*p_out_nbits-1:0];
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ostream_msg = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == CW'(i)) begin
`ifdef SEC08_QUEUES_SERIALIZER_MSB_FIRST_EN
            ostream_msg = buf_q[N-1-i];
`else
            ostream_msg = buf_q[i];
`endif
         end
      end
   end

endmodule
